regbus_arbiter: RTL and testbench
=================================

# regbus_arbiter

Two-master arbiter that shares one single-outstanding register-bus slave port (RdMem/WrMem strobes, RdDone/WrDone acknowledges, 32-bit data) between the VME host path and the local configuration sequencer. It sits directly in front of a generated register block. It serialises accesses with round-robin fairness, issues one-cycle strobes and routes acknowledge and read data back to the owning master. An optional watchdog terminates accesses the slave never acknowledges.

## Interface
- AW, 14: address width (byte address).
- DW, 32: data width.
- TIMEOUT, 255: watchdog limit in clk cycles (≥2); used only with the watchdog compiled in.

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- m0_addr / m1_addr  in  AW  master address, stable while request high
- m0_wdata / m1_wdata  in  DW  write data, stable while wr request high
- m0_rd_req / m1_rd_req  in  1  read request, level, held until done
- m0_wr_req / m1_wr_req  in  1  write request, level, held until done
- m0_rdata / m1_rdata  out  DW  read data, valid with rd_done
- m0_rd_done / m1_rd_done  out  1  one-cycle read completion
- m0_wr_done / m1_wr_done  out  1  one-cycle write completion
- m0_err / m1_err  out  1  one-cycle timeout flag, coincident with done
- s_addr  out  AW  slave address
- s_wdata  out  DW  slave write data
- s_rd_mem / s_wr_mem  out  1  one-cycle slave strobes
- s_rdata  in  DW  slave read data, valid with s_rd_done
- s_rd_done / s_wr_done  in  1  slave acknowledges

## Operation
- FSM states and transitions:
  - IDLE: pick a requester. Both request → the master not served last wins; pointer resets to m0 preferred. Latch index, op, addr and wdata, then go to ISSUE.
  - ISSUE: one cycle. Assert s_rd_mem or s_wr_mem. A matching done in this cycle goes to DONE; otherwise go to WAIT.
  - WAIT: hold strobes low and wait for the done matching the latched op.
  - DONE: one cycle. Pulse the owner's rd_done/wr_done, update the pointer, return to IDLE.
- A master's rd_req and wr_req both high: read is served first. The write stays pending and is arbitrated afresh.
- Done of the wrong type, or done in IDLE: ignored.
- m*_rdata is registered from s_rdata on s_rd_done. It holds until the next read completion for that master.
- s_addr and s_wdata are driven from latched values and are stable from ISSUE through DONE.
- Reset values: all dones, err and strobes 0; rdata, s_addr and s_wdata 0; state IDLE; pointer favours m0.
- Reset mid-access: abort to IDLE with no done to any master. A late slave done is discarded.

## Timing
- Request sampled high in IDLE at cycle t → strobe at t+1.
- Slave done at cycle d → master done at d+1 (d ≥ t+1).
- With the slave block's one-cycle acknowledge, minimum access is 3 cycles (IDLE, ISSUE, DONE), plus 1 if the slave acks one cycle after the strobe.
- Back-to-back: after DONE the next IDLE arbitrates. A master may drop its request on the done cycle; a request still high then is a new access.
- Throughput: at most one access per 3 cycles.

## Configuration
- REGBUS_ARB_TIMEOUT_EN defined:
  - A counter clears on ISSUE and increments in WAIT.
  - On reaching TIMEOUT, go to DONE with owner err=1 and the done type of the latched op; rdata for a timed-out read is 0.
  - Counter width is $clog2(TIMEOUT+1).
- Not defined: no counter; WAIT lasts until the slave acknowledges; m*_err tied 0.

## Structure
- Package regbus_arb_pkg:
  - state enum (IDLE, ISSUE, WAIT, DONE)
  - op type (RD, WR)
  - master index type
  - default TIMEOUT constant
- Sub-module regbus_rr_pick: two-requester round-robin selector taking the request vector and last-served pointer, returning grant index and valid. It is the only natural split; everything else stays in regbus_arbiter.

## Test plan
- m0 write 0x0000_1FFF to addr 0x0, slave acks 1 cycle after strobe → s_wr_mem one cycle with s_wdata=0x1FFF, m0_wr_done 2 cycles later, m1 untouched.
- m0 and m1 read together, with m0 last served → m1 granted first. m0 strobe follows m1's DONE. rdata routed per master (0xA5, 0x5A).
- m0 holds rd_req and wr_req → read completes first, then the write. Neither done duplicated.
- With REGBUS_ARB_TIMEOUT_EN and TIMEOUT=8, slave never acks → m1_rd_done and m1_err at cycle 8 of WAIT+1, m1_rdata=0. Without the macro, the FSM stays in WAIT.
- rst_n low during WAIT, then the slave acks after release → no master done, state IDLE, strobes 0 throughout.
- Spurious s_wr_done in IDLE and s_rd_done during a write → ignored; the write completes only on s_wr_done.

Source files
------------

// File: rtl/regbus_arb_pkg.sv
// regbus_arb_pkg
// Shared types and defaults for the register-bus arbiter slice.
//   state_e   : arbiter FSM encoding (IDLE, ISSUE, WAIT, DONE)
//   op_e      : latched access type (read / write)
//   mst_idx_t : master index (0 = VME host path, 1 = config sequencer)
//   DEFAULT_* : default address/data widths and watchdog limit
package regbus_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    typedef logic mst_idx_t;

    localparam int DEFAULT_AW      = 14;
    localparam int DEFAULT_DW      = 32;
    localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/regbus_arbiter_if.sv
// regbus_arbiter_if
// One register-bus link. Used for both master links and the slave link.
//   addr, wdata    : address / write data from the initiator
//   rd, wr         : on a master link these are level requests held until
//                    done; on the slave link they are one-cycle RdMem/WrMem
//                    strobes
//   rdata          : read data, valid with rd_done
//   rd_done/wr_done: one-cycle completions
//   err            : one-cycle timeout flag coincident with done (master
//                    links only; the slave side ties it low)
// Modports: master = initiator view, slave = responder view.
interface regbus_arbiter_if
    import regbus_arb_pkg::*;
#(
    parameter int AW = DEFAULT_AW,
    parameter int DW = DEFAULT_DW
);
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          rd;
    logic          wr;
    logic [DW-1:0] rdata;
    logic          rd_done;
    logic          wr_done;
    logic          err;

    modport master (
        output addr, wdata, rd, wr,
        input  rdata, rd_done, wr_done, err
    );

    modport slave (
        input  addr, wdata, rd, wr,
        output rdata, rd_done, wr_done, err
    );
endinterface

// File: rtl/regbus_rr_pick.sv
// regbus_rr_pick
// Two-requester round-robin selector.
//   req   in  2  request vector (bit i = master i wants the bus)
//   last  in  1  master served most recently
//   grant out 1  index of the winning master
//   valid out 1  at least one request present
module regbus_rr_pick
    import regbus_arb_pkg::*;
(
    input  logic [1:0] req,
    input  mst_idx_t   last,
    output mst_idx_t   grant,
    output logic       valid
);
    // On contention the master that was not served last wins; otherwise the
    // lone requester wins (index 0 when nobody asks, qualified by valid).
    always_comb begin
        valid = |req;
        if (req[0] && req[1]) begin
            grant = ~last;
        end else begin
            grant = req[1];
        end
    end
endmodule

// File: rtl/regbus_arbiter.sv
// regbus_arbiter
// Shares one single-outstanding register-bus slave between two masters
// (m0 = VME host path, m1 = local configuration sequencer) with round-robin
// fairness. Accesses are serialised through IDLE -> ISSUE -> (WAIT) -> DONE.
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  synchronous active-low reset
//   m0, m1     master links (slave modport): level requests in, done/rdata/err out
//   s          slave link (master modport): one-cycle strobes out, acks in
// Parameters: AW address width, DW data width, TIMEOUT watchdog limit (>=2).
// Build option: define REGBUS_ARB_TIMEOUT_EN to compile in the watchdog that
// terminates accesses the slave never acknowledges (err=1, read data 0).
module regbus_arbiter
    import regbus_arb_pkg::*;
#(
    parameter int AW      = DEFAULT_AW,
    parameter int DW      = DEFAULT_DW,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    regbus_arbiter_if.slave  m0,
    regbus_arbiter_if.slave  m1,
    regbus_arbiter_if.master s
);
    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] ISSUE = ST_ISSUE;
    localparam logic [1:0] WAIT  = ST_WAIT;
    localparam logic [1:0] DONE  = ST_DONE;

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("regbus_arbiter: TIMEOUT must be at least 2");
    end

    logic [1:0]    state;
    mst_idx_t      owner;
    mst_idx_t      last_served;
    op_e           op;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;

    logic [1:0]    req;
    mst_idx_t      grant;
    logic          grant_valid;
    logic          grant_rd;
    logic [AW-1:0] grant_addr;
    logic [DW-1:0] grant_wdata;
    logic          busy;
    logic          op_done;
    logic          rd_capture;
    logic          timeout_fire;

    assign req = {m1.rd | m1.wr, m0.rd | m0.wr};

    regbus_rr_pick u_pick (
        .req   (req),
        .last  (last_served),
        .grant (grant),
        .valid (grant_valid)
    );

    // A master raising both rd and wr gets its read first; the write stays
    // pending and competes again in the next IDLE.
    assign grant_rd    = grant ? m1.rd    : m0.rd;
    assign grant_addr  = grant ? m1.addr  : m0.addr;
    assign grant_wdata = grant ? m1.wdata : m0.wdata;

    // Only the acknowledge matching the latched op counts, and only while an
    // access is on the bus; everything else from the slave is ignored.
    assign busy       = (state == ISSUE) || (state == WAIT);
    assign op_done    = (op == OP_RD) ? s.rd_done : s.wr_done;
    assign rd_capture = busy && (op == OP_RD) && s.rd_done;

`ifdef REGBUS_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;
    logic          err_q;

    // The counter would reach TIMEOUT at the end of this WAIT cycle.
    assign timeout_fire = (state == WAIT) && !op_done && (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            if (state == ISSUE) begin
                cnt <= '0;
            end else if (state == WAIT) begin
                cnt <= cnt + CW'(1);
            end
            if (state == IDLE) begin
                err_q <= 1'b0;
            end else if (timeout_fire) begin
                err_q <= 1'b1;
            end
        end
    end

    assign m0.err = (state == DONE) && (owner == 1'b0) && err_q;
    assign m1.err = (state == DONE) && (owner == 1'b1) && err_q;
`else
    assign timeout_fire = 1'b0;
    assign m0.err       = 1'b0;
    assign m1.err       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last_served <= 1'b1;
            op          <= OP_RD;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner   <= grant;
                        op      <= grant_rd ? OP_RD : OP_WR;
                        addr_q  <= grant_addr;
                        wdata_q <= grant_wdata;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= op_done ? DONE : WAIT;
                end
                WAIT: begin
                    if (op_done || timeout_fire) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    last_served <= owner;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Per-master read data holds until that master's next read completes;
    // a timed-out read returns zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else if (rd_capture) begin
            if (owner) rdata1_q <= s.rdata;
            else       rdata0_q <= s.rdata;
        end else if (timeout_fire && (op == OP_RD)) begin
            if (owner) rdata1_q <= '0;
            else       rdata0_q <= '0;
        end
    end

    assign s.addr  = addr_q;
    assign s.wdata = wdata_q;
    assign s.rd    = (state == ISSUE) && (op == OP_RD);
    assign s.wr    = (state == ISSUE) && (op == OP_WR);

    assign m0.rdata   = rdata0_q;
    assign m1.rdata   = rdata1_q;
    assign m0.rd_done = (state == DONE) && (owner == 1'b0) && (op == OP_RD);
    assign m0.wr_done = (state == DONE) && (owner == 1'b0) && (op == OP_WR);
    assign m1.rd_done = (state == DONE) && (owner == 1'b1) && (op == OP_RD);
    assign m1.wr_done = (state == DONE) && (owner == 1'b1) && (op == OP_WR);
endmodule

// File: tb/tb_regbus_arbiter.sv
// tb_regbus_arbiter
// Self-checking bench for regbus_arbiter: table of single accesses, then
// hand-written sequences for contention, rd+wr on one master, spurious acks,
// watchdog (when REGBUS_ARB_TIMEOUT_EN is defined) and reset mid-access.
// A behavioural slave acknowledges after a programmable latency.
module tb_regbus_arbiter;
    localparam int AW = 14;
    localparam int DW = 32;
    localparam int TO = 8;

    typedef struct {
        int            mst;
        bit            rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
        int            ack_lat;
    } vec_t;

    typedef struct {
        int            mst;
        bit            rd;
        logic [DW-1:0] rdata;
        bit            err;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    regbus_arbiter_if #(.AW(AW), .DW(DW)) m0_if ();
    regbus_arbiter_if #(.AW(AW), .DW(DW)) m1_if ();
    regbus_arbiter_if #(.AW(AW), .DW(DW)) s_if ();

    regbus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .m0    (m0_if),
        .m1    (m1_if),
        .s     (s_if)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    int   done_cnt [2];

    logic [1:0] rdd, wrd, errv;
    assign rdd  = {m1_if.rd_done, m0_if.rd_done};
    assign wrd  = {m1_if.wr_done, m0_if.wr_done};
    assign errv = {m1_if.err, m0_if.err};

    // Slave model state
    logic [DW-1:0] mem [16];
    int            ack_lat    = 0;
    bit            slave_mute = 1'b0;
    int            pend       = 0;
    bit            pend_rd;
    logic [AW-1:0] pend_addr;
    int            inj_rd_cyc = -1;
    int            inj_wr_cyc = -1;
    int            strobe_cnt = 0;
    logic [AW-1:0] last_addr  = '0;
    logic [AW-1:0] prev_addr  = '0;
    logic [DW-1:0] last_wdata = '0;
    int            last_cyc   = 0;
    int            prev_cyc   = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural slave: sees strobes on the falling edge, acks now or after
    // ack_lat cycles, plus scheduled spurious acks carrying junk data.
    always @(negedge clk) begin
        logic          ack_rd;
        logic          ack_wr;
        logic [DW-1:0] rd_val;
        ack_rd = 1'b0;
        ack_wr = 1'b0;
        rd_val = 32'hBAD0_0BAD;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                if (pend_rd) begin
                    ack_rd = 1'b1;
                    rd_val = mem[pend_addr[5:2]];
                end else begin
                    ack_wr = 1'b1;
                end
            end
        end
        if (s_if.rd === 1'b1 || s_if.wr === 1'b1) begin
            strobe_cnt++;
            prev_addr  = last_addr;
            prev_cyc   = last_cyc;
            last_addr  = s_if.addr;
            last_wdata = s_if.wdata;
            last_cyc   = cyc;
            if (s_if.wr === 1'b1) mem[s_if.addr[5:2]] = s_if.wdata;
            if (!slave_mute) begin
                if (ack_lat == 0) begin
                    if (s_if.rd === 1'b1) begin
                        ack_rd = 1'b1;
                        rd_val = mem[s_if.addr[5:2]];
                    end else begin
                        ack_wr = 1'b1;
                    end
                end else begin
                    pend      = ack_lat;
                    pend_rd   = (s_if.rd === 1'b1);
                    pend_addr = s_if.addr;
                end
            end
        end
        if (cyc == inj_rd_cyc) ack_rd = 1'b1;
        if (cyc == inj_wr_cyc) ack_wr = 1'b1;
        s_if.rd_done = ack_rd;
        s_if.wr_done = ack_wr;
        s_if.rdata   = rd_val;
        s_if.err     = 1'b0;
    end

    // Scoreboard: every master done pops one expected completion.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rdd[i] === 1'b1 || wrd[i] === 1'b1) begin
                exp_t e;
                done_cnt[i]++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_done m%0d: got rd_done=%0b wr_done=%0b, required none", i, rdd[i], wrd[i]);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("done_owner", i, e.mst);
                    checkOutput("done_rd", {31'b0, rdd[i]}, {31'b0, e.rd});
                    checkOutput("done_wr", {31'b0, wrd[i]}, {31'b0, !e.rd});
                    checkOutput("done_err", {31'b0, errv[i]}, {31'b0, e.err});
                    if (e.rd) checkOutput("done_rdata", (i == 1) ? m1_if.rdata : m0_if.rdata, e.rdata);
                end
            end
        end
    end

    task automatic setReq(input int mst, input bit rd, input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        if (mst == 0) begin
            m0_if.rd = rd; m0_if.wr = wr; m0_if.addr = addr; m0_if.wdata = wdata;
        end else begin
            m1_if.rd = rd; m1_if.wr = wr; m1_if.addr = addr; m1_if.wdata = wdata;
        end
    endtask

    task automatic waitDone(input int mst, input int budget, output int lat);
        int start;
        start = done_cnt[mst];
        lat   = 0;
        while (done_cnt[mst] == start && lat < budget) begin
            @(negedge clk);
            #1;
            lat++;
        end
        if (done_cnt[mst] == start) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL done_timeout m%0d: got no done in %0d cycles, required a done", mst, budget);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        int lat;
        exp_q.push_back('{mst: v.mst, rd: v.rd, rdata: v.exp_rdata, err: 1'b0});
        ack_lat = v.ack_lat;
        setReq(v.mst, v.rd, !v.rd, v.addr, v.wdata);
        waitDone(v.mst, 40, lat);
        setReq(v.mst, 1'b0, 1'b0, v.addr, v.wdata);
        checkOutput("latency", lat, 3 + v.ack_lat);
        checkOutput("s_addr", {18'b0, last_addr}, {18'b0, v.addr});
        if (!v.rd) checkOutput("s_wdata", last_wdata, v.wdata);
        else       checkOutput("m_rdata_hold", (v.mst == 1) ? m1_if.rdata : m0_if.rdata, v.exp_rdata);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL global_timeout: got no end of test, required $finish");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        vec_t tab [9];
        int   lat;
        int   sc;
        int   d0;
        int   d1;

        tab[0] = '{0, 1'b0, 14'h0000, 32'h0000_1FFF, 32'h0, 1};
        tab[1] = '{1, 1'b0, 14'h0004, 32'h0000_00A5, 32'h0, 0};
        tab[2] = '{0, 1'b0, 14'h0008, 32'h0000_005A, 32'h0, 0};
        tab[3] = '{1, 1'b1, 14'h0004, 32'h0, 32'h0000_00A5, 1};
        tab[4] = '{0, 1'b1, 14'h0008, 32'h0, 32'h0000_005A, 0};
        tab[5] = '{0, 1'b1, 14'h0000, 32'h0, 32'h0000_1FFF, 2};
        tab[6] = '{1, 1'b0, 14'h3FFC, 32'hFFFF_FFFF, 32'h0, 0};
        tab[7] = '{1, 1'b1, 14'h3FFC, 32'h0, 32'hFFFF_FFFF, 1};
        tab[8] = '{0, 1'b1, 14'h0008, 32'h0, 32'h0000_005A, 0};

        for (int i = 0; i < 16; i++) mem[i] = 32'h100 + i;
        done_cnt[0] = 0;
        done_cnt[1] = 0;
        setReq(0, 1'b0, 1'b0, '0, '0);
        setReq(1, 1'b0, 1'b0, '0, '0);

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_strobes", {30'b0, s_if.rd, s_if.wr}, 0);
        checkOutput("rst_s_addr", {18'b0, s_if.addr}, 0);
        checkOutput("rst_s_wdata", s_if.wdata, 0);
        checkOutput("rst_dones", {28'b0, rdd, wrd}, 0);
        checkOutput("rst_err", {30'b0, errv}, 0);
        checkOutput("rst_m0_rdata", m0_if.rdata, 0);
        checkOutput("rst_m1_rdata", m1_if.rdata, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] table of single accesses");
        for (int i = 0; i < 9; i++) applyStimulus(tab[i]);

        $display("[TB] contention after m0 served: m1 first");
        exp_q.push_back('{mst: 1, rd: 1'b1, rdata: 32'h0000_00A5, err: 1'b0});
        exp_q.push_back('{mst: 0, rd: 1'b1, rdata: 32'h0000_005A, err: 1'b0});
        ack_lat = 0;
        sc = strobe_cnt;
        setReq(0, 1'b1, 1'b0, 14'h0008, '0);
        setReq(1, 1'b1, 1'b0, 14'h0004, '0);
        waitDone(1, 20, lat);
        setReq(1, 1'b0, 1'b0, '0, '0);
        checkOutput("rr_m1_lat", lat, 3);
        waitDone(0, 20, lat);
        setReq(0, 1'b0, 1'b0, '0, '0);
        checkOutput("rr_m0_lat", lat, 3);
        checkOutput("rr_first_addr", {18'b0, prev_addr}, 32'h4);
        checkOutput("rr_second_addr", {18'b0, last_addr}, 32'h8);
        checkOutput("rr_strobe_gap", last_cyc - prev_cyc, 3);
        checkOutput("rr_strobes", strobe_cnt - sc, 2);
        @(posedge clk);
        #1;

        $display("[TB] m0 holds rd and wr");
        exp_q.push_back('{mst: 0, rd: 1'b1, rdata: 32'h0000_0103, err: 1'b0});
        exp_q.push_back('{mst: 0, rd: 1'b0, rdata: 32'h0, err: 1'b0});
        d0 = done_cnt[0];
        setReq(0, 1'b1, 1'b1, 14'h000C, 32'hCAFE_0003);
        waitDone(0, 20, lat);
        m0_if.rd = 1'b0;
        checkOutput("rdwr_read_lat", lat, 3);
        waitDone(0, 20, lat);
        setReq(0, 1'b0, 1'b0, '0, '0);
        checkOutput("rdwr_write_lat", lat, 3);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("rdwr_done_count", done_cnt[0] - d0, 2);
        checkOutput("rdwr_mem", mem[3], 32'hCAFE_0003);
        checkOutput("rdwr_rdata", m0_if.rdata, 32'h0000_0103);

        $display("[TB] spurious acknowledges");
        sc = strobe_cnt;
        d0 = done_cnt[0];
        d1 = done_cnt[1];
        inj_wr_cyc = cyc + 1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("spur_idle_strobes", strobe_cnt - sc, 0);
        checkOutput("spur_idle_dones", (done_cnt[0] - d0) + (done_cnt[1] - d1), 0);
        inj_rd_cyc = cyc + 2;
        applyStimulus('{0, 1'b0, 14'h0010, 32'h0000_7777, 32'h0, 4});
        checkOutput("spur_rdata_kept", m0_if.rdata, 32'h0000_0103);

`ifdef REGBUS_ARB_TIMEOUT_EN
        $display("[TB] watchdog on an unacknowledged read");
        slave_mute = 1'b1;
        exp_q.push_back('{mst: 1, rd: 1'b1, rdata: 32'h0, err: 1'b1});
        setReq(1, 1'b1, 1'b0, 14'h0004, '0);
        waitDone(1, 40, lat);
        setReq(1, 1'b0, 1'b0, '0, '0);
        slave_mute = 1'b0;
        checkOutput("wdog_lat", lat, TO + 3);
        checkOutput("wdog_rdata", m1_if.rdata, 0);
        @(posedge clk);
        #1;
`else
        $display("[TB] unacknowledged read stays pending");
        slave_mute = 1'b1;
        sc = strobe_cnt;
        d1 = done_cnt[1];
        setReq(1, 1'b1, 1'b0, 14'h0004, '0);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("hang_dones", done_cnt[1] - d1, 0);
        checkOutput("hang_strobes", strobe_cnt - sc, 1);
        rst_n = 1'b0;
        setReq(1, 1'b0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        slave_mute = 1'b0;
        @(posedge clk);
        #1;
`endif

        $display("[TB] reset during WAIT");
        slave_mute = 1'b1;
        setReq(0, 1'b1, 1'b0, 14'h0008, '0);
        repeat (4) @(posedge clk);
        #1;
        sc = strobe_cnt;
        d0 = done_cnt[0];
        d1 = done_cnt[1];
        rst_n = 1'b0;
        setReq(0, 1'b0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        slave_mute = 1'b0;
        inj_rd_cyc = cyc + 1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("rstw_strobes", strobe_cnt - sc, 0);
        checkOutput("rstw_dones", (done_cnt[0] - d0) + (done_cnt[1] - d1), 0);
        checkOutput("rstw_m0_rdata", m0_if.rdata, 0);
        checkOutput("rstw_m1_rdata", m1_if.rdata, 0);
        checkOutput("rstw_s_addr", {18'b0, s_if.addr}, 0);

        $display("[TB] contention after reset: m0 first");
        exp_q.push_back('{mst: 0, rd: 1'b1, rdata: 32'h0000_005A, err: 1'b0});
        exp_q.push_back('{mst: 1, rd: 1'b1, rdata: 32'h0000_00A5, err: 1'b0});
        ack_lat = 0;
        setReq(0, 1'b1, 1'b0, 14'h0008, '0);
        setReq(1, 1'b1, 1'b0, 14'h0004, '0);
        waitDone(0, 20, lat);
        setReq(0, 1'b0, 1'b0, '0, '0);
        checkOutput("post_rst_m0_lat", lat, 3);
        waitDone(1, 20, lat);
        setReq(1, 1'b0, 1'b0, '0, '0);
        checkOutput("post_rst_first_addr", {18'b0, prev_addr}, 32'h8);
        checkOutput("post_rst_second_addr", {18'b0, last_addr}, 32'h4);
        repeat (4) @(posedge clk);
        #1;

        checkOutput("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
